// File: rtl/visibility_prefetch.sv
// Sweeps every visibility word out of the correlator blocks after each bank swap,
// using credit-limited pipelined burst reads, and streams them through an 8-deep FIFO.
module visibility_prefetch #(
  parameter int unsigned BLOCK = 24,
  parameter int unsigned ABITS = 10,
  parameter int unsigned UNITS = 6,
  parameter int unsigned WORDS = 96,
  parameter int unsigned FBITS = 3,
  parameter int unsigned DELAY = 3
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             switch,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic             bst_o,
  output logic [ABITS-1:0] adr_o,
  input  logic             ack_i,
  input  logic [BLOCK-1:0] dat_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [BLOCK-1:0] dat_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overrun_o
);

  localparam int unsigned      DEPTH     = 1 << FBITS;
  localparam logic [FBITS+1:0] DEPTH_C   = (FBITS+2)'(DEPTH);
  localparam logic [6:0]       LAST_WORD = 7'(WORDS - 1);
  localparam logic [2:0]       LAST_UNIT = 3'(UNITS - 1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, GAP} state_t;

  state_t           state, state_nx;
  logic [6:0]       word, word_nx;
  logic [2:0]       unit, unit_nx;
  logic [FBITS:0]   outst, outst_nx;
  logic [FBITS:0]   count, count_nx;
  logic [FBITS+1:0] credit_sum;
  logic [FBITS-1:0] wr_ptr, rd_ptr;
  logic [BLOCK-1:0] mem [DEPTH];
  logic             push, pop;
  logic             stb_nx, cyc_nx, bst_nx, done_nx;

  always_comb begin
    push       = ack_i && cyc_o;
    pop        = valid_o && ready_i;
    outst_nx   = outst + {{FBITS{1'b0}}, stb_o} - {{FBITS{1'b0}}, push};
    count_nx   = count + {{FBITS{1'b0}}, push} - {{FBITS{1'b0}}, pop};
    credit_sum = {1'b0, count_nx} + {1'b0, outst_nx};
    state_nx   = state;
    unit_nx    = unit;
    word_nx    = word + {6'b0, stb_o};
    case (state)
      IDLE:    if (switch) state_nx = REQ;
      REQ:     if (stb_o && word == LAST_WORD) state_nx = DRAIN;
      DRAIN:   if (outst_nx == '0) state_nx = GAP;
      GAP: begin
        word_nx = '0;
        if (unit == LAST_UNIT) begin
          state_nx = IDLE;
          unit_nx  = '0;
        end else begin
          state_nx = REQ;
          unit_nx  = unit + 3'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Outputs are registered, so the strobe decision uses next-cycle credit counts;
    // the first REQ cycle after IDLE never strobes.
    stb_nx  = (state_nx == REQ) && (state != IDLE) && (credit_sum < DEPTH_C);
    cyc_nx  = ((state_nx == REQ) || (state_nx == DRAIN)) && (state != IDLE);
    bst_nx  = stb_nx && (word_nx != LAST_WORD);
    done_nx = (state == DRAIN) && (state_nx == GAP) && (unit == LAST_UNIT);
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state     <= IDLE;
      word      <= '0;
      unit      <= '0;
      outst     <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem       <= '{default: '0};
      cyc_o     <= 1'b0;
      stb_o     <= 1'b0;
      bst_o     <= 1'b0;
      adr_o     <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      state  <= state_nx;
      word   <= word_nx;
      unit   <= unit_nx;
      outst  <= outst_nx;
      count  <= count_nx;
      cyc_o  <= cyc_nx;
      stb_o  <= stb_nx;
      bst_o  <= bst_nx;
      adr_o  <= ABITS'({unit_nx, word_nx});
      busy_o <= (state_nx != IDLE);
      done_o <= done_nx;
      if (switch && state != IDLE) overrun_o <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= dat_i;
        wr_ptr      <= wr_ptr + FBITS'(1);
      end
      if (pop) rd_ptr <= rd_ptr + FBITS'(1);
    end
  end

  assign we_o    = 1'b0;
  assign valid_o = (count != '0);
  assign dat_o   = mem[rd_ptr];

endmodule

// File: tb/tb_visibility_prefetch.sv
// Directed bench for visibility_prefetch: in-order slave model with programmable ack
// latency, FIFO/credit shadow counts, and per-sweep stream/address/burst checks.
module tb_visibility_prefetch;
  localparam int BLOCK = 24;
  localparam int ABITS = 10;
  localparam int UNITS = 6;
  localparam int WORDS = 96;
  localparam int TOTAL = UNITS * WORDS;

  logic             clk_i = 1'b0;
  logic             rst = 1'b1;
  logic             switch = 1'b0;
  logic             cyc_o, stb_o, we_o, bst_o;
  logic [ABITS-1:0] adr_o;
  logic             ack_i = 1'b0;
  logic [BLOCK-1:0] dat_i = '0;
  logic             valid_o;
  logic             ready_i = 1'b0;
  logic [BLOCK-1:0] dat_o;
  logic             busy_o, done_o, overrun_o;

  visibility_prefetch #(
    .BLOCK(BLOCK), .ABITS(ABITS), .UNITS(UNITS), .WORDS(WORDS), .FBITS(3), .DELAY(3)
  ) dut (
    .clk_i(clk_i), .rst(rst), .switch(switch),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .bst_o(bst_o), .adr_o(adr_o),
    .ack_i(ack_i), .dat_i(dat_i),
    .valid_o(valid_o), .ready_i(ready_i), .dat_o(dat_o),
    .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // Stimulus knobs
  int lat_min = 2, lat_max = 2, rdy_mode = 0;
  int rst_trig = -1, ovr_trig = -1;
  bit sw_pend = 0, rst_hit = 0;
  // Slave and shadow state
  logic [ABITS-1:0] pend_adr[$];
  int pend_due[$];
  int cyc_n = 0, last_due = 0;
  int fifo_cnt = 0, outst = 0, max_sum = 0, max_out = 0;
  // Per-sweep tallies
  int n_stb, n_ack, n_pop, adr_err, bst_err, we_err, order_err, credit_viol;
  int gap_err, cyc_rises, low_run, done_cnt, done_err;
  bit prev_done, prev_cyc;

  function automatic logic [31:0] exp_adr(input int idx);
    return 32'(((idx / WORDS) << 7) + (idx % WORDS));
  endfunction

  task automatic clear_sweep();
    n_stb = 0; n_ack = 0; n_pop = 0; adr_err = 0; bst_err = 0; we_err = 0;
    order_err = 0; credit_viol = 0; gap_err = 0; cyc_rises = 0; low_run = 0;
    done_cnt = 0; done_err = 0; prev_done = 0; prev_cyc = 0;
  endtask

  task automatic tick();
    logic ack, push, pop, stb;
    int due;
    @(posedge clk_i);
    #1;
    cyc_n++;
    stb = stb_o;
    if (we_o) we_err++;
    if (stb) begin
      if (fifo_cnt + outst >= 8) credit_viol++;
      if (adr_o != ABITS'(exp_adr(n_stb))) adr_err++;
      if (bst_o != ((n_stb % WORDS) != WORDS - 1)) bst_err++;
      if (rst_trig >= 0 && n_stb == rst_trig) rst_hit = 1;
      if (ovr_trig >= 0 && n_stb == ovr_trig) sw_pend = 1;
      due = cyc_n + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_adr.push_back(adr_o);
      pend_due.push_back(due);
      n_stb++;
    end else if (bst_o) bst_err++;
    // cyc_o must stay low for exactly one busy cycle before each unit
    if (cyc_o) begin
      if (!prev_cyc) begin
        cyc_rises++;
        if (low_run != 1) gap_err++;
      end
      low_run = 0;
    end else if (busy_o) low_run++;
    else low_run = 0;
    prev_cyc = cyc_o;
    if (prev_done && busy_o) done_err++;
    if (done_o) begin
      done_cnt++;
      if (n_ack != TOTAL) done_err++;
    end
    prev_done = done_o;
    ack = (pend_due.size() > 0) && (pend_due[0] == cyc_n);
    ack_i = ack;
    if (ack) begin
      dat_i = BLOCK'(pend_adr[0]);
      void'(pend_adr.pop_front());
      void'(pend_due.pop_front());
    end else dat_i = BLOCK'($urandom);
    push = ack && cyc_o;
    ready_i = (rdy_mode == 2) ? 1'($urandom_range(1, 0)) : (rdy_mode == 1);
    pop = valid_o && ready_i;
    if (pop) begin
      if (dat_o != BLOCK'(exp_adr(n_pop))) order_err++;
      n_pop++;
    end
    if (push) n_ack++;
    fifo_cnt += int'(push) - int'(pop);
    outst    += int'(stb) - int'(push);
    if (fifo_cnt + outst > max_sum) max_sum = fifo_cnt + outst;
    if (outst > max_out) max_out = outst;
    switch = sw_pend;
    sw_pend = 0;
  endtask

  task automatic start_sweep(input string name);
    clear_sweep();
    sw_pend = 1;
    tick();
    tick();
    check({name, "_busy_at_t"}, busy_o, 1);
    check({name, "_cyc_at_t"}, cyc_o, 0);
    tick();
    check({name, "_cyc_at_t1"}, cyc_o, 1);
    check({name, "_stb_at_t1"}, stb_o, 1);
    check({name, "_adr_at_t1"}, adr_o, 0);
  endtask

  task automatic run_sweep(input string name, input int budget);
    int n = 0;
    while ((n_pop < TOTAL || done_cnt == 0) && n < budget) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check({name, "_timeout"}, n >= budget, 0);
    check({name, "_words_out"}, n_pop, TOTAL);
    check({name, "_strobes"}, n_stb, TOTAL);
    check({name, "_acks"}, n_ack, TOTAL);
    check({name, "_order_err"}, order_err, 0);
    check({name, "_adr_err"}, adr_err, 0);
    check({name, "_bst_err"}, bst_err, 0);
    check({name, "_we_err"}, we_err, 0);
    check({name, "_credit_viol"}, credit_viol, 0);
    check({name, "_cyc_rises"}, cyc_rises, UNITS);
    check({name, "_gap_err"}, gap_err, 0);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_done_err"}, done_err, 0);
    check({name, "_busy_end"}, busy_o, 0);
    check({name, "_valid_end"}, valid_o, 0);
  endtask

  initial begin
    clear_sweep();
    tick();
    tick();
    check("rst_cyc", cyc_o, 0);
    check("rst_stb", stb_o, 0);
    check("rst_bst", bst_o, 0);
    check("rst_adr", adr_o, 0);
    check("rst_we", we_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_dat", dat_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_overrun", overrun_o, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Basic sweep, fixed latency 2, always ready
    lat_min = 2; lat_max = 2; rdy_mode = 1;
    start_sweep("basic");
    run_sweep("basic", 5000);
    check("basic_overrun", overrun_o, 0);

    // Backpressure: consumer stalled, then a single pop, then free-running
    rdy_mode = 0;
    start_sweep("bp");
    repeat (40) tick();
    check("bp_strobes_stalled", n_stb, 8);
    check("bp_stb_low", stb_o, 0);
    check("bp_cyc_held", cyc_o, 1);
    check("bp_valid", valid_o, 1);
    check("bp_head", dat_o, 0);
    rdy_mode = 1;
    tick();
    rdy_mode = 0;
    tick();
    check("bp_resume", stb_o, 1);
    repeat (5) tick();
    check("bp_one_credit", n_stb, 9);
    rdy_mode = 1;
    run_sweep("bp", 5000);

    // Overrun at strobe 100, then a fresh sweep after done
    lat_min = 1; lat_max = 1; ovr_trig = 100;
    start_sweep("ovr");
    check("ovr_clear_before", overrun_o, 0);
    run_sweep("ovr", 5000);
    ovr_trig = -1;
    check("ovr_sticky", overrun_o, 1);
    lat_min = 4; lat_max = 4;
    start_sweep("restart");
    run_sweep("restart", 5000);
    check("ovr_still_set", overrun_o, 1);

    // Reset at unit 3 word 40
    lat_min = 3; lat_max = 3; rst_trig = 3 * WORDS + 40; rst_hit = 0;
    start_sweep("rstmid");
    for (int i = 0; i < 3000 && !rst_hit; i++) tick();
    check("rstmid_trigger_seen", rst_hit, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_cyc", cyc_o, 0);
    check("rstmid_stb", stb_o, 0);
    check("rstmid_valid", valid_o, 0);
    check("rstmid_busy", busy_o, 0);
    check("rstmid_adr", adr_o, 0);
    check("rstmid_dat", dat_o, 0);
    check("rstmid_overrun", overrun_o, 0);
    rst_trig = -1;
    fifo_cnt = 0; outst = 0; max_sum = 0; max_out = 0;
    clear_sweep();
    repeat (10) tick();
    check("rstmid_stale_acks_dropped", valid_o, 0);
    check("rstmid_idle_busy", busy_o, 0);

    // Slow slave after reset: random latency 1..6, random ready
    lat_min = 1; lat_max = 6; rdy_mode = 2;
    start_sweep("slow");
    run_sweep("slow", 8000);
    check("slow_max_outstanding_ok", max_out <= 8, 1);
    check("slow_max_credit_sum_ok", max_sum <= 8, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
